// File: rtl/clk_div_checker.sv
// clk_div_checker: receive-side self-check for a clk-derived divided clock.
// div_in is sampled on both clk edges (half-cycle resolution); each period
// (rising sample to rising sample) and its high time are measured in
// half-cycles and compared against EXP_PER_HC / EXP_HI_HC +/- TOL_HC.
// Ports:
//   clk, rstn (async, active low), en (low = idle and cleared)
//   div_in       divided clock under check
//   meas_valid   1-cycle pulse, new measurement on meas_per_hc / meas_hi_hc
//   err_per/err_duty  pulses alongside meas_valid when out of tolerance
//   locked       LOCK_N consecutive good periods, no error since
//   stuck        no rising sample for 2*EXP_PER_HC half-cycles
module clk_div_checker #(
  parameter int EXP_PER_HC = 6,
  parameter int EXP_HI_HC  = 3,
  parameter int TOL_HC     = 0,
  parameter int LOCK_N     = 4,
  parameter int CW         = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          div_in,
  output logic          meas_valid,
  output logic [CW-1:0] meas_per_hc,
  output logic [CW-1:0] meas_hi_hc,
  output logic          err_per,
  output logic          err_duty,
  output logic          locked,
  output logic          stuck
);
  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_e;

  localparam int          GW      = $clog2(LOCK_N + 1);
  localparam logic [CW:0] CMAX    = {1'b0, {CW{1'b1}}};
  localparam logic [CW:0] TOL     = (CW+1)'(TOL_HC);
  localparam logic [CW:0] PER_EXP = (CW+1)'(EXP_PER_HC);
  localparam logic [CW:0] PER_MAX = (CW+1)'(EXP_PER_HC + TOL_HC);
  localparam logic [CW:0] HI_EXP  = (CW+1)'(EXP_HI_HC);
  localparam logic [CW:0] HI_MAX  = (CW+1)'(EXP_HI_HC + TOL_HC);
  localparam logic [CW:0] TO_LIM  = (CW+1)'(2 * EXP_PER_HC);
  localparam logic [GW-1:0] LOCK_G = GW'(LOCK_N);

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {{(CW-1){1'b0}}, b};
    return (s > CMAX) ? CMAX[CW-1:0] : s[CW-1:0];
  endfunction

  // Half-sample captured at the negedge between two posedges
  logic neg_q, neg_d;
  always_comb neg_d = en & div_in;
  always_ff @(negedge clk or negedge rstn)
    if (!rstn) neg_q <= 1'b0;
    else       neg_q <= neg_d;

  state_e        state_q, state_d;
  logic [CW-1:0] per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
  logic [GW-1:0] good_q, good_d;
  logic          prev_q, prev_d;
  logic          meas_valid_q, meas_valid_d, err_per_q, err_per_d, err_duty_q, err_duty_d;
  logic [CW-1:0] meas_per_q, meas_per_d, meas_hi_q, meas_hi_d;
  logic          locked_q, locked_d, stuck_q, stuck_d;

  logic          rise0, rise1, rise, timeout, bad_per, bad_hi;
  logic [CW-1:0] acc_per, acc_hi, cls_per, rst_per, rst_hi;
  logic [GW-1:0] good_inc;

  always_comb begin
    // Ordered samples this posedge: neg_q (older), div_in (newer)
    rise0   = neg_q & ~prev_q;
    rise1   = div_in & ~neg_q;
    rise    = rise0 | rise1;
    acc_per = sat_add(per_cnt_q, 2'd2);
    acc_hi  = sat_add(hi_cnt_q, {1'b0, neg_q} + {1'b0, div_in});
    // Closed span: if the rise is the newer sample, the older (a 0) belongs to it
    cls_per = rise0 ? per_cnt_q : sat_add(per_cnt_q, 2'd1);
    // Restarted span includes the rising sample and anything after it
    rst_per = rise0 ? CW'(2) : CW'(1);
    rst_hi  = (rise0 && div_in) ? CW'(2) : CW'(1);
    bad_per = ({1'b0, cls_per} > PER_MAX) || ({1'b0, cls_per} + TOL < PER_EXP) ||
              (cls_per == CMAX[CW-1:0]);
    bad_hi  = ({1'b0, hi_cnt_q} > HI_MAX) || ({1'b0, hi_cnt_q} + TOL < HI_EXP);
    timeout = ({1'b0, acc_per} >= TO_LIM);
    good_inc = (good_q == LOCK_G) ? LOCK_G : good_q + GW'(1);

    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    hi_cnt_d     = hi_cnt_q;
    good_d       = good_q;
    prev_d       = div_in;
    meas_valid_d = 1'b0;
    err_per_d    = 1'b0;
    err_duty_d   = 1'b0;
    meas_per_d   = meas_per_q;
    meas_hi_d    = meas_hi_q;
    locked_d     = locked_q;
    stuck_d      = stuck_q;

    if (!en) begin
      state_d    = IDLE;
      per_cnt_d  = '0;
      hi_cnt_d   = '0;
      good_d     = '0;
      prev_d     = 1'b0;
      meas_per_d = '0;
      meas_hi_d  = '0;
      locked_d   = 1'b0;
      stuck_d    = 1'b0;
    end else if (rise) begin
      per_cnt_d = rst_per;
      hi_cnt_d  = rst_hi;
      state_d   = MEAS;
      stuck_d   = 1'b0;
      // The first rise after IDLE/ARM only opens a span; nothing to report
      if (state_q == MEAS) begin
        meas_valid_d = 1'b1;
        meas_per_d   = cls_per;
        meas_hi_d    = hi_cnt_q;
        err_per_d    = bad_per;
        err_duty_d   = bad_hi;
        if (bad_per || bad_hi) begin
          good_d   = '0;
          locked_d = 1'b0;
        end else begin
          good_d   = good_inc;
          locked_d = (good_inc == LOCK_G);
        end
      end
    end else begin
      per_cnt_d = acc_per;
      hi_cnt_d  = acc_hi;
      if (state_q == IDLE) state_d = ARM;
      if (timeout) begin
        state_d  = ARM;
        stuck_d  = 1'b1;
        locked_d = 1'b0;
        good_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      per_cnt_q    <= '0;
      hi_cnt_q     <= '0;
      good_q       <= '0;
      prev_q       <= 1'b0;
      meas_valid_q <= 1'b0;
      err_per_q    <= 1'b0;
      err_duty_q   <= 1'b0;
      meas_per_q   <= '0;
      meas_hi_q    <= '0;
      locked_q     <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      good_q       <= good_d;
      prev_q       <= prev_d;
      meas_valid_q <= meas_valid_d;
      err_per_q    <= err_per_d;
      err_duty_q   <= err_duty_d;
      meas_per_q   <= meas_per_d;
      meas_hi_q    <= meas_hi_d;
      locked_q     <= locked_d;
      stuck_q      <= stuck_d;
    end
  end

  assign meas_valid  = meas_valid_q;
  assign meas_per_hc = meas_per_q;
  assign meas_hi_hc  = meas_hi_q;
  assign err_per     = err_per_q;
  assign err_duty    = err_duty_q;
  assign locked      = locked_q;
  assign stuck       = stuck_q;
endmodule
